// File: rtl/qmax_scan.sv
// Scans all actions of one state over the Q-table's registered read port and
// reports the largest signed Q-value together with the action that holds it.
module qmax_scan #(
  parameter int STATE_WIDTH = 6,
  parameter int ACTION_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  localparam int ADDR_WIDTH = STATE_WIDTH + ACTION_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [STATE_WIDTH-1:0]  i_state,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [DATA_WIDTH-1:0]   o_max_q,
  output logic [ACTION_WIDTH-1:0] o_max_action,
  output logic [ADDR_WIDTH-1:0]   o_addr_r,
  output logic                    o_read_en,
  input  logic [DATA_WIDTH-1:0]   i_q_data
);

  // state | meaning
  // IDLE  | waiting for i_start; result registers hold the last scan
  // ISSUE | one read per cycle, action 0 .. NUM_ACTIONS-1
  // DRAIN | last read datum arrives and is folded into the result
  localparam int NUM_ACTIONS = 2 ** ACTION_WIDTH;
  localparam logic [ACTION_WIDTH-1:0] LAST_ACT = ACTION_WIDTH'(NUM_ACTIONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_n;
  logic [STATE_WIDTH-1:0]  scan_state, scan_state_n;
  logic [ACTION_WIDTH-1:0] act, act_n;
  logic                    busy_n, done_n, read_en_n;
  logic [ADDR_WIDTH-1:0]   addr_n;

  logic                    vld;
  logic [ACTION_WIDTH-1:0] act_d;
  logic [DATA_WIDTH-1:0]   run_max, cand_q;
  logic [ACTION_WIDTH-1:0] run_act, cand_act;
  logic                    take;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      scan_state <= '0;
      act        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_read_en  <= 1'b0;
      o_addr_r   <= '0;
    end else begin
      state      <= state_n;
      scan_state <= scan_state_n;
      act        <= act_n;
      o_busy     <= busy_n;
      o_done     <= done_n;
      o_read_en  <= read_en_n;
      o_addr_r   <= addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    scan_state_n = scan_state;
    act_n        = act;
    read_en_n    = 1'b0;
    done_n       = 1'b0;
    addr_n       = o_addr_r;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_n      = ISSUE;
          scan_state_n = i_state;
          act_n        = '0;
          read_en_n    = 1'b1;
          addr_n       = {i_state, {ACTION_WIDTH{1'b0}}};
        end
      end
      ISSUE: begin
        if (act == LAST_ACT) begin
          state_n = DRAIN;
        end else begin
          act_n     = act + 1'b1;
          read_en_n = 1'b1;
          addr_n    = {scan_state, act_n};
        end
      end
      DRAIN: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Action 0 seeds the running max; ties keep the earlier (lower) action.
  always_comb begin
    take     = (act_d == '0) || ($signed(i_q_data) > $signed(run_max));
    cand_q   = take ? i_q_data : run_max;
    cand_act = take ? act_d : run_act;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld          <= 1'b0;
      act_d        <= '0;
      run_max      <= '0;
      run_act      <= '0;
      o_max_q      <= '0;
      o_max_action <= '0;
    end else begin
      vld   <= o_read_en;
      act_d <= act;
      if (vld) begin
        run_max <= cand_q;
        run_act <= cand_act;
        if (act_d == LAST_ACT) begin
          o_max_q      <= cand_q;
          o_max_action <= cand_act;
        end
      end
    end
  end

endmodule

// File: tb/tb_qmax_scan.sv
// Bench for qmax_scan: a memory model answers reads one cycle late and a
// plain loop over the stored Q-values predicts the max/argmax of each scan.
module tb_qmax_scan;
  localparam int NA = 4;

  logic       i_clk = 1'b0;
  logic       i_rst, i_start;
  logic [5:0] i_state;
  logic       o_busy, o_done, o_read_en;
  logic [7:0] o_max_q, i_q_data;
  logic [1:0] o_max_action;
  logic [7:0] o_addr_r;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  qmax_scan dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_state(i_state),
    .o_busy(o_busy), .o_done(o_done), .o_max_q(o_max_q),
    .o_max_action(o_max_action), .o_addr_r(o_addr_r),
    .o_read_en(o_read_en), .i_q_data(i_q_data)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_read_en) i_q_data <= mem[o_addr_r];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_max(input logic [5:0] s, output logic [7:0] mq, output logic [1:0] ma);
    int best;
    int v;
    best = -1000;
    ma = 2'd0;
    for (int a = 0; a < NA; a++) begin
      v = $signed(mem[{s, 2'(a)}]);
      if (v > best) begin
        best = v;
        ma = 2'(a);
      end
    end
    mq = 8'(best);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      chk("idle_done", o_done, 1'b0);
      chk("idle_rd", o_read_en, 1'b0);
    end
  endtask

  // Call at a negedge; returns at the negedge of the o_done cycle so a
  // following call starts back-to-back.
  task automatic do_scan(input logic [5:0] s, input int busy_start_k, input int rst_k);
    logic [7:0] mq;
    logic [1:0] ma;
    ref_max(s, mq, ma);
    i_start = 1'b1;
    i_state = s;
    for (int k = 1; k <= NA + 2; k++) begin
      @(negedge i_clk);
      chk("busy", o_busy, k <= NA + 1);
      chk("rd_en", o_read_en, k <= NA);
      if (k <= NA) chk("addr", o_addr_r, {s, 2'(k - 1)});
      chk("done", o_done, k == NA + 2);
      if (k == NA + 2) begin
        chk("max_q", o_max_q, mq);
        chk("max_act", o_max_action, ma);
      end
      i_start = 1'b0;
      i_state = 6'($urandom);
      if (k == busy_start_k) begin
        i_start = 1'b1;
        i_state = 6'd2;
      end
      if (k == rst_k) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_rd", o_read_en, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_q", o_max_q, 8'd0);
        chk("rst_act", o_max_action, 2'd0);
        idle(4);
        return;
      end
    end
  endtask

  task automatic fill(input logic [5:0] s, input bit ties);
    logic [7:0] pool [5];
    pool[0] = 8'h80; pool[1] = 8'hFF; pool[2] = 8'h00; pool[3] = 8'h05; pool[4] = 8'h7F;
    for (int a = 0; a < NA; a++)
      mem[{s, 2'(a)}] = ties ? pool[$urandom_range(0, 4)] : 8'($urandom);
  endtask

  initial begin
    logic [5:0] s;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_state = '0;
    i_q_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(negedge i_clk);
    chk("r_busy", o_busy, 1'b0);
    chk("r_done", o_done, 1'b0);
    chk("r_rd", o_read_en, 1'b0);
    chk("r_addr", o_addr_r, 8'd0);
    chk("r_q", o_max_q, 8'd0);
    chk("r_act", o_max_action, 2'd0);
    i_rst = 1'b0;
    idle(3);

    mem[20] = 8'd10; mem[21] = 8'd40; mem[22] = 8'hFD; mem[23] = 8'd25;
    do_scan(6'd5, 0, 0);
    chk("basic_q", o_max_q, 8'd40);
    chk("basic_act", o_max_action, 2'd1);
    idle(2);

    mem[252] = 8'h80; mem[253] = 8'hF9; mem[254] = 8'hF9; mem[255] = 8'h9C;
    do_scan(6'd63, 0, 0);
    chk("sign_q", o_max_q, 8'hF9);
    chk("sign_act", o_max_action, 2'd1);
    idle(2);

    do_scan(6'd7, 0, 0);
    chk("zero_q", o_max_q, 8'd0);
    chk("zero_act", o_max_action, 2'd0);
    idle(2);

    do_scan(6'd5, 3, 0);
    idle(4);
    chk("ign_q", o_max_q, 8'd40);

    fill(6'd9, 1'b0);
    do_scan(6'd5, 0, 0);
    do_scan(6'd9, 0, 0);
    idle(2);

    do_scan(6'd9, 0, 3);
    do_scan(6'd5, 0, 0);
    chk("post_rst_q", o_max_q, 8'd40);
    idle(2);

    repeat (40) begin
      s = 6'($urandom);
      fill(s, $urandom_range(0, 1) == 1);
      do_scan(s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end
endmodule

// File: doc/qmax_scan.md
Name: qmax_scan

Overview:
- Consumer stage on the Q-table read port; finds the largest Q-value over all actions of one state and reports which action holds it.
- Given a state, it reads the Q-values of every action of that state from the Q-table, one per cycle, over the table's 1-cycle registered read port.
- Returns the maximum Q-value and its argmax action.
- Feeds the Q-update path (max term of the Bellman target) and the greedy action selector.

Parameters:
- STATE_WIDTH, 6, state index width
- ACTION_WIDTH, 2, action index width; NUM_ACTIONS = 2**ACTION_WIDTH
- DATA_WIDTH, 8, Q-value width, signed two's complement
- ADDR_WIDTH, STATE_WIDTH+ACTION_WIDTH, Q-table address width (derived, not overridden)

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_start  input  1  request a scan; accepted only when o_busy=0
- i_state  input  STATE_WIDTH  state to scan; sampled with accepted i_start
- o_busy  output  1  scan in progress
- o_done  output  1  one-cycle pulse: result valid and updated
- o_max_q  output  DATA_WIDTH  maximum Q-value of last completed scan
- o_max_action  output  ACTION_WIDTH  action index of o_max_q
- o_addr_r  output  ADDR_WIDTH  Q-table read address = {state, action}, state in MSBs
- o_read_en  output  1  Q-table read enable
- i_q_data  input  DATA_WIDTH  Q-table read data; valid the cycle after o_read_en

Behaviour:
- Reset (i_rst=1 at clock edge):
  - state -> IDLE.
  - o_busy, o_done, o_read_en, o_addr_r, o_max_q and o_max_action all 0.
  - Internal action counter and pipeline valid flag cleared.
  - Reset mid-scan aborts the scan; no o_done is issued for it.
- FSM states: IDLE, ISSUE, DRAIN. All outputs are registered.
- IDLE:
  - i_start=1 at edge E0: latch i_state, action counter=0, go to ISSUE.
  - i_start ignored while o_busy=1.
- ISSUE:
  - Lasts NUM_ACTIONS cycles. o_read_en=1; o_addr_r={state, counter}; counter increments each cycle.
  - After the cycle with counter=NUM_ACTIONS-1, go to DRAIN.
- DRAIN:
  - Lasts one cycle with o_read_en=0; the last read datum is consumed here.
  - Then go to IDLE and pulse o_done.
- Compare pipeline:
  - A valid flag, delayed one cycle from o_read_en, qualifies i_q_data; a matching delayed action index accompanies it.
  - First valid datum initialises the running max and argmax unconditionally.
  - Each later datum replaces the running max only if it is strictly greater, compared signed. Ties keep the lower action index.
- Completion:
  - On the edge that consumes the final datum, o_max_q and o_max_action load the running result and o_done=1 for exactly one cycle.
  - o_max_q and o_max_action hold until the next o_done or reset.
- Timing (cycle k = k cycles after the start edge E0):
  - o_busy=1 for cycles 1..NUM_ACTIONS+1.
  - o_read_en=1 for cycles 1..NUM_ACTIONS.
  - o_done=1 in cycle NUM_ACTIONS+2, with o_busy=0 in that cycle.
  - Latency is 6 cycles at defaults.
- Back-to-back: i_start in the o_done cycle is accepted. Throughput is one scan per NUM_ACTIONS+2 cycles.
- i_state changes after acceptance have no effect on the scan in progress.
- Arithmetic: comparison only, no overflow possible. The most negative value (-128) is a legal Q-value.

Test Plan:
- Reset then idle: hold i_rst 3 cycles, then no start → all outputs 0; o_read_en stays 0.
- Basic scan, state 5 with Q = {10, 40, -3, 25} at addresses 20..23:
  - o_addr_r reads 20, 21, 22, 23 in cycles 1..4.
  - o_done in cycle 6 with o_max_q=40, o_max_action=1.
- Signed and ties, state 63 with Q = {-128, -7, -7, -100} → o_max_q=-7 (0xF9), o_max_action=1. All Q=0 → o_max_q=0, o_max_action=0.
- Start ignored while busy: i_start with state 2 in cycle 3 of a state-5 scan → no extra reads; result is for state 5 only, and exactly one o_done.
- Back-to-back: second i_start (state 9) in the o_done cycle → reads of addresses 36..39 begin the next cycle; second o_done 6 cycles later.
- Reset mid-scan: i_rst in cycle 3 → next cycle o_busy=0 and o_read_en=0; no o_done; o_max_q and o_max_action=0. A new scan afterwards completes correctly.
